// File: rtl/regfile_pkg.sv
// Types and constants shared by the register file, the decode stage and the writeback queue.
package regfile_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // "reg" is a keyword, so the destination index field is named rd.
  typedef struct packed {
    logic              is_float;
    logic [REG_AW-1:0] rd;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

  function automatic logic same_dest(input wb_entry_t e, input logic f, input logic [REG_AW-1:0] r);
    return (e.is_float == f) && (e.rd == r);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback queue: two write ports per cycle, one head read port,
// per-slot valid bits and a youngest-match content search over queued entries.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push0_i,
  input  wb_entry_t                din0_i,
  input  logic                     push1_i,
  input  wb_entry_t                din1_i,
  input  logic                     pop_i,
  output wb_entry_t                head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  input  logic                     srch_float_i,
  input  logic [REG_AW-1:0]        srch_reg_i,
  output logic                     srch_hit_o,
  output logic [REG_DW-1:0]        srch_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wr1_ptr;

  // The second write lands behind the first only when the first is also used.
  assign wr1_ptr = wr_ptr_q + PW'(push0_i);

  always_comb begin
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    if (pop_i) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    // Pushes are applied after the pop so a full queue can refill the slot it drains.
    if (push0_i) vld_d[wr_ptr_q] = 1'b1;
    if (push1_i) vld_d[wr1_ptr]  = 1'b1;
    wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
    cnt_d    = cnt_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0_i) mem_q[wr_ptr_q] <= din0_i;
    if (push1_i) mem_q[wr1_ptr]  <= din1_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    srch_hit_o  = 1'b0;
    srch_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (vld_q[idx] && same_dest(mem_q[idx], srch_float_i, srch_reg_i)) begin
        srch_hit_o  = 1'b1;
        srch_data_o = mem_q[idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Write-side initiator for the 32x32 int/float register file: arbitrates two result
// producers into an in-order queue, drains one write per cycle and answers hazard queries.
module regfile_writeback_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = REG_DW,
  parameter int AW    = REG_AW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [AW-1:0]           a_reg,
  input  logic                    a_float,
  input  logic [DW-1:0]           a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [AW-1:0]           b_reg,
  input  logic                    b_float,
  input  logic [DW-1:0]           b_data,
  output logic                    regWrite,
  output logic                    float,
  output logic [AW-1:0]           writeReg,
  output logic [DW-1:0]           writeData,
  input  logic [AW-1:0]           q_reg,
  input  logic                    q_float,
  output logic                    q_hit,
  output logic [DW-1:0]           q_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int  CW   = $clog2(DEPTH) + 1;
  localparam logic RR_A = 1'b0;

  logic            rr_q, rr_d;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   free;
  logic            a_r0, b_r0, a_nz, b_nz;
  logic            push_a, push_b, pop;
  wb_entry_t       ent_a, ent_b, head;
  logic            srch_hit;
  logic [REG_DW-1:0] srch_data;

  assign a_r0 = a_valid && (a_reg == REG_ZERO);
  assign b_r0 = b_valid && (b_reg == REG_ZERO);
  assign a_nz = a_valid && !a_r0;
  assign b_nz = b_valid && !b_r0;

  // The slot freed by this cycle's pop is usable by this cycle's push.
  assign pop  = (cnt != '0);
  assign free = CW'(DEPTH) - cnt + CW'(pop);

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    rr_d    = rr_q;
    if (free == '0) begin
      a_ready = 1'b0;
      b_ready = 1'b0;
    end else if (free >= CW'(2) || a_r0 || b_r0) begin
      // An r0 request needs no slot, so only one real push can be pending.
      a_ready = 1'b1;
      b_ready = 1'b1;
    end else begin
      if (rr_q == RR_A) begin
        a_ready = a_valid;
        b_ready = !a_valid;
      end else begin
        b_ready = b_valid;
        a_ready = !b_valid;
      end
      if (a_nz && b_nz) rr_d = ~rr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= RR_A;
    else       rr_q <= rr_d;
  end

  assign push_a = a_nz && a_ready;
  assign push_b = b_nz && b_ready;

  assign ent_a = '{is_float: a_float, rd: a_reg, data: a_data};
  assign ent_b = '{is_float: b_float, rd: b_reg, data: b_data};

  // Accepted entries are packed onto the low write port first, keeping A ahead of B.
  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push0_i      (push_a || push_b),
    .din0_i       (push_a ? ent_a : ent_b),
    .push1_i      (push_a && push_b),
    .din1_i       (ent_b),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (cnt),
    .srch_float_i (q_float),
    .srch_reg_i   (q_reg),
    .srch_hit_o   (srch_hit),
    .srch_data_o  (srch_data)
  );

  // Head storage is not reset, so the write port is masked whenever the queue is empty.
  assign regWrite  = pop;
  assign float     = pop && head.is_float;
  assign writeReg  = pop ? head.rd : '0;
  assign writeData = pop ? head.data : '0;
  assign count     = cnt;

  assign q_hit  = srch_hit && (q_reg != REG_ZERO);
  assign q_data = q_hit ? srch_data : '0;

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Randomized bench for regfile_writeback_ctrl against a queue-based reference model.
module tb_regfile_writeback_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_float, b_valid, b_float, q_float;
  logic [4:0]  a_reg, b_reg, q_reg;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, regWrite, wr_float, q_hit;
  logic [4:0]  writeReg;
  logic [31:0] writeData, q_data;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit        f;
    bit [4:0]  r;
    bit [31:0] d;
  } ent_t;

  ent_t mq[$];
  bit   rr_m = 1'b0;   // 0: A preferred at the next contention, 1: B

  regfile_writeback_ctrl #(.DEPTH(DEPTH), .DW(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_float(a_float), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_float(b_float), .b_data(b_data),
    .regWrite(regWrite), .float(wr_float), .writeReg(writeReg), .writeData(writeData),
    .q_reg(q_reg), .q_float(q_float), .q_hit(q_hit), .q_data(q_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model before the posedge,
  // advance the model at the posedge, return 1 time unit after it.
  task automatic step(input bit rst,
                      input bit av, input bit af, input bit [4:0] ar, input bit [31:0] ad,
                      input bit bv, input bit bf, input bit [4:0] br, input bit [31:0] bd,
                      input bit qf, input bit [4:0] qr);
    int  sz, free;
    bit  ar0, br0, ea, eb, eh;
    bit  [31:0] eqd;
    @(negedge clk);
    reset = rst; q_float = qf; q_reg = qr;
    a_valid = av; a_float = af; a_reg = ar; a_data = ad;
    b_valid = bv; b_float = bf; b_reg = br; b_data = bd;
    #1;
    sz   = mq.size();
    free = DEPTH - sz + ((sz != 0) ? 1 : 0);
    ar0  = av && (ar == 0);
    br0  = bv && (br == 0);
    ea = 0; eb = 0;
    if (free >= 2 || (free == 1 && (ar0 || br0))) begin
      ea = 1; eb = 1;
    end else if (free == 1) begin
      if (rr_m == 0) begin if (av) ea = 1; else eb = 1; end
      else           begin if (bv) eb = 1; else ea = 1; end
    end
    eh = 0; eqd = 0;
    if (qr != 0) foreach (mq[i]) if (mq[i].f == qf && mq[i].r == qr) begin eh = 1; eqd = mq[i].d; end
    if (!rst) begin
      check_val("a_ready", a_ready, ea);
      check_val("b_ready", b_ready, eb);
      check_val("count", count, sz);
      check_val("regWrite", regWrite, sz != 0);
      check_val("float", wr_float, (sz != 0) ? mq[0].f : 1'b0);
      check_val("writeReg", writeReg, (sz != 0) ? mq[0].r : 5'd0);
      check_val("writeData", writeData, (sz != 0) ? mq[0].d : 32'd0);
      check_val("q_hit", q_hit, eh);
      check_val("q_data", q_data, eqd);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      rr_m = 0;
    end else begin
      if (sz != 0) void'(mq.pop_front());
      if (av && ea && !ar0) mq.push_back('{af, ar, ad});
      if (bv && eb && !br0) mq.push_back('{bf, br, bd});
      if (free == 1 && av && bv && !ar0 && !br0) rr_m = ~rr_m;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; a_valid = 0; b_valid = 0; a_float = 0; b_float = 0;
    a_reg = 0; b_reg = 0; a_data = 0; b_data = 0; q_reg = 0; q_float = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("rst_count", count, 0);
    check_val("rst_regWrite", regWrite, 0);
    check_val("rst_writeReg", writeReg, 0);
    check_val("rst_writeData", writeData, 0);
    check_val("rst_q_hit", q_hit, 0);

    // Single write
    step(0, 1, 0, 5, 32'h1234, 0, 0, 0, 0, 0, 0);
    check_val("single_regWrite", regWrite, 1);
    check_val("single_float", wr_float, 0);
    check_val("single_writeReg", writeReg, 5);
    check_val("single_writeData", writeData, 32'h1234);
    idle(1);
    check_val("single_drained", count, 0);

    // Dual accept, A ahead of B
    step(0, 1, 0, 3, 32'hA, 1, 1, 3, 32'hB, 0, 0);
    check_val("dual_count", count, 2);
    check_val("dual_first_float", wr_float, 0);
    check_val("dual_first_data", writeData, 32'hA);
    idle(1);
    check_val("dual_second_float", wr_float, 1);
    check_val("dual_second_reg", writeReg, 3);
    check_val("dual_second_data", writeData, 32'hB);
    idle(2);

    // r0 filter
    step(0, 1, 0, 0, 32'hFF, 1, 1, 0, 32'hEE, 0, 0);
    check_val("r0_count", count, 0);
    check_val("r0_regWrite", regWrite, 0);
    idle(1);

    // Query: youngest match wins; bank must match
    step(0, 1, 1, 7, 32'h11, 1, 1, 7, 32'h22, 1, 7);
    check_val("query_hit", q_hit, 1);
    check_val("query_data", q_data, 32'h22);
    q_float = 0;
    #1;
    check_val("query_int_hit", q_hit, 0);
    check_val("query_int_data", q_data, 0);
    idle(3);

    // Contention at free==1: grants must alternate
    for (int i = 0; i < 12; i++)
      step(0, 1, 0, 5'(1 + i % 7), 32'(100 + i), 1, 1, 5'(9 + i % 5), 32'(200 + i), 0, 5'(1 + i % 7));
    idle(5);

    // Reset mid-stream with 3 entries queued
    step(0, 1, 0, 4, 32'hC1, 1, 0, 6, 32'hC2, 0, 0);
    step(0, 1, 1, 8, 32'hC3, 1, 0, 9, 32'hC4, 0, 0);
    check_val("pre_rst_count", count, 3);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("mid_rst_count", count, 0);
    check_val("mid_rst_regWrite", regWrite, 0);
    idle(4);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0),
           $urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom), 5'($urandom_range(0, 7)));
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
